// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: default width, LSB-mode selectors and
// reference encode/decode functions at the default width.
package gray_pkg;
  localparam int GRAY_W_DEFAULT     = 10;
  localparam int LSB_MODE_CODEBASE  = 0;
  localparam int LSB_MODE_REFLECTED = 1;

  typedef logic [GRAY_W_DEFAULT-1:0] gray_t;

  function automatic gray_t gray2bin(gray_t code, int lsb_mode);
    gray_t b;
    b[GRAY_W_DEFAULT-1] = code[GRAY_W_DEFAULT-1];
    for (int i = GRAY_W_DEFAULT - 2; i >= 0; i--) b[i] = code[i] ^ b[i+1];
    // Codebase encoding carries bit 0 through unmixed.
    if (lsb_mode == LSB_MODE_CODEBASE) b[0] = code[0];
    return b;
  endfunction

  function automatic gray_t bin2gray(gray_t bin, int lsb_mode);
    gray_t g;
    g = bin ^ (bin >> 1);
    if (lsb_mode == LSB_MODE_CODEBASE) g[0] = bin[0];
    return g;
  endfunction
endpackage

// File: rtl/gray_to_binary_comb.sv
// Pure combinational Gray-to-binary decode; each bit is a reduction of the
// code bits at and above it, so there is no rippling self-reference.
module gray_to_binary_comb
  import gray_pkg::*;
#(
  parameter int W        = GRAY_W_DEFAULT,
  parameter int LSB_MODE = LSB_MODE_CODEBASE
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  for (genvar i = 1; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

  if (LSB_MODE == LSB_MODE_CODEBASE) begin : g_lsb_cb
    assign bin[0] = gray[0];
  end else begin : g_lsb_rf
    assign bin[0] = ^gray;
  end
endmodule

// File: rtl/gray_to_binary_pipe.sv
// Two-stage handshaked Gray decoder with +1 step checking and a saturating
// discontinuity counter for debug.
module gray_to_binary_pipe
  import gray_pkg::*;
#(
  parameter int W        = GRAY_W_DEFAULT,
  parameter int LSB_MODE = LSB_MODE_CODEBASE,
  parameter int ERRW     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_gray,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_bin,
  output logic            out_step_err,
  output logic [ERRW-1:0] err_count,
  input  logic            clr_err
);
  logic         s1_valid;
  logic [W-1:0] s1_gray;
  logic [W-1:0] dec;
  logic [W-1:0] prev;
  logic         have_prev;
  logic         s2_adv;
  logic         s1_adv;
  logic         step_err;

  // Ready chain is combinational end to end, so a full pipe still moves
  // one item per cycle when the consumer is ready.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign s1_adv   = s1_valid && s2_adv;

  gray_to_binary_comb #(.W(W), .LSB_MODE(LSB_MODE)) u_dec (
    .gray (s1_gray),
    .bin  (dec)
  );

  assign step_err = have_prev && (dec != prev + W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_gray  <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) s1_gray <= in_gray;
    end
  end

  // Output payload is only updated on a real transfer so it holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_bin      <= '0;
      out_step_err <= 1'b0;
      prev         <= '0;
      have_prev    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_bin      <= dec;
        out_step_err <= step_err;
        prev         <= dec;
        have_prev    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (s1_adv && step_err && (err_count != '1)) begin
      err_count <= err_count + ERRW'(1);
    end
  end
endmodule

// File: tb/tb_gray_to_binary_pipe.sv
// Scoreboard bench: codebase-mode and reflected-mode (ERRW=2) decoders share
// one randomized stream; expectations come from arithmetic Gray rules.
module tb_gray_to_binary_pipe;
  localparam int W    = 10;
  localparam int MOD  = 1 << W;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, clr_err;
  logic [W-1:0] in_gray;
  logic rdy0, rdy1, ov0, ov1, se0, se1;
  logic [W-1:0] ob0, ob1;
  logic [7:0] ec0;
  logic [1:0] ec1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] bin0;
    logic         err0;
    logic [W-1:0] bin1;
    logic         err1;
  } exp_t;
  exp_t q[$];

  int prev0, prev1, cnt0, cnt1;
  bit hp;
  int rdy_mode;

  always #5 clk = ~clk;

  gray_to_binary_pipe #(.W(W), .LSB_MODE(0), .ERRW(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_gray(in_gray),
    .out_valid(ov0), .out_ready(out_ready), .out_bin(ob0), .out_step_err(se0),
    .err_count(ec0), .clr_err(clr_err));

  gray_to_binary_pipe #(.W(W), .LSB_MODE(1), .ERRW(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_gray(in_gray),
    .out_valid(ov1), .out_ready(out_ready), .out_bin(ob1), .out_step_err(se1),
    .err_count(ec1), .clr_err(clr_err));

  // Codebase encoding: reflected Gray with bit 0 passed through unmixed.
  function automatic logic [W-1:0] enc(int b);
    logic [W-1:0] v, g;
    v = W'(b);
    g = v ^ (v >> 1);
    g[0] = v[0];
    return g;
  endfunction

  function automatic int refl_dec(logic [W-1:0] g);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) r ^= g >> k;
    return int'(r);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(int b);
    exp_t e;
    int d;
    d = refl_dec(enc(b));
    e.bin0 = W'(b);
    e.err0 = hp && ((b % MOD) != ((prev0 + 1) % MOD));
    e.bin1 = W'(d);
    e.err1 = hp && (d != ((prev1 + 1) % MOD));
    if (e.err0 && cnt0 < 255) cnt0++;
    if (e.err1 && cnt1 < 3) cnt1++;
    prev0 = b % MOD;
    prev1 = d;
    hp = 1'b1;
    q.push_back(e);
  endtask

  task automatic cyc(input bit v, input int b, output bit acc);
    @(negedge clk);
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    in_valid = v;
    in_gray  = enc(b);
    #1;
    acc = v && rdy0;
    if (v) chk("in_ready_match", rdy1, rdy0);
    @(posedge clk);
    if (acc) push(b);
    #1 in_valid = 1'b0;
  endtask

  int waits;
  task automatic send(int b);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      cyc(1'b1, b, acc);
      n++;
    end
    waits += n - 1;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(int n);
    bit acc;
    repeat (n) cyc(1'b0, 0, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1 chk("rst_out_valid", ov0, 0);
    q.delete();
    hp = 1'b0; prev0 = 0; prev1 = 0; cnt0 = 0; cnt1 = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: out_ready for the coming edge is already driven at negedge+2.
  logic [W-1:0] h0, h1;
  logic         hs0;
  bit           held = 1'b0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst) begin
      held = 1'b0;
    end else begin
      chk("valid_match", ov1, ov0);
      if (held) begin
        chk("stall_valid", ov0, 1);
        chk("stall_bin0", ob0, h0);
        chk("stall_bin1", ob1, h1);
        chk("stall_err0", se0, hs0);
      end
      held = 1'b0;
      if (ov0 && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out_bin0", ob0, e.bin0);
          chk("step_err0", se0, e.err0);
          chk("out_bin1", ob1, e.bin1);
          chk("step_err1", se1, e.err1);
        end
      end else if (ov0) begin
        held = 1'b1;
        h0 = ob0; h1 = ob1; hs0 = se0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, nxt, c;
    bit acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0; in_gray = '0;
    rdy_mode = 0; waits = 0;
    hp = 1'b0; prev0 = 0; prev1 = 0; cnt0 = 0; cnt1 = 0;
    #2;
    chk("reset_out_valid", ov0, 0);
    chk("reset_out_bin", ob0, 0);
    chk("reset_step_err", se0, 0);
    chk("reset_err_count", ec0, 0);
    chk("reset_in_ready", rdy0, 1);
    @(negedge clk);
    rst = 1'b0;

    // Single value 0x3FE (Gray 0x200): latency 2, both decode modes.
    send(12'h3FE);
    @(negedge clk); #1 chk("lat_not_yet", ov0, 0);
    @(negedge clk); #1 chk("lat_valid", ov0, 1);
    chk("first_bin_cb", ob0, 10'h3FE);
    chk("first_bin_rf", ob1, 10'h3FF);
    chk("first_no_err", se0, 0);
    idle(3);

    // Full count plus wrap, back to back.
    do_reset();
    waits = 0;
    for (int v = 0; v < MOD; v++) send(v);
    send(0);
    idle(4);
    chk("wrap_no_stall", waits, 0);
    chk("wrap_err_count", ec0, cnt0);
    chk("wrap_err_zero", ec0, 0);

    // Discontinuities and clear-wins-over-increment.
    do_reset();
    send(5); send(6); send(7); send(9); send(9);
    idle(4);
    chk("step_err_count", ec0, 2);
    chk("step_err_model", ec0, cnt0);
    send(20);
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    cnt0 = 0; cnt1 = 0;
    idle(3);
    chk("clr_wins0", ec0, 0);
    chk("clr_wins1", ec1, 0);

    // Backpressure: random ready, then 5 cycles held low.
    do_reset();
    nxt = 100; c = 0;
    while (nxt <= 109 && c < 400) begin
      if (c == 9) chk("in_ready_full", rdy0, 0);
      rdy_mode = (c >= 4 && c < 9) ? 2 : 1;
      cyc(1'b1, nxt, acc);
      if (acc) nxt++;
      c++;
    end
    rdy_mode = 0;
    idle(4);
    chk("bp_all_sent", nxt, 110);
    chk("bp_drained", q.size(), 0);
    chk("bp_err_count", ec0, 0);

    // Saturation on the 2-bit counter: five repeats.
    do_reset();
    repeat (6) send(1);
    idle(4);
    chk("sat_count1", ec1, 3);
    chk("sat_count0", ec0, 5);

    // Random mostly-incrementing stream with random backpressure.
    do_reset();
    rdy_mode = 1;
    b = $urandom_range(0, MOD - 1);
    repeat (150) begin
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, MOD - 1);
      else b = (b + 1) % MOD;
      send(b);
    end
    rdy_mode = 0;
    idle(4);
    chk("rand_drained", q.size(), 0);
    chk("rand_count0", ec0, cnt0);
    chk("rand_count1", ec1, cnt1);

    // Reset with both stages full, then history must be forgotten.
    do_reset();
    rdy_mode = 2;
    send(300); send(301);
    idle(1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("async_drop0", ov0, 0);
    chk("async_drop1", ov1, 0);
    q.delete();
    hp = 1'b0; prev0 = 0; prev1 = 0; cnt0 = 0; cnt1 = 0;
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    send(42); send(7);
    idle(4);
    chk("post_rst_count", ec0, 1);
    chk("post_rst_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
